// File: rtl/operand_fetch.sv
// operand_fetch: two-slot operand read stage with writeback forwarding, x0 zeroing and output-slot snooping
module operand_fetch #(
  parameter int XLEN = 64,
  parameter int IW   = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [IW-1:0]   in_inst,
  output logic [4:0]      rf_r_reg1,
  output logic [4:0]      rf_r_reg2,
  input  logic [XLEN-1:0] rf_r_data1,
  input  logic [XLEN-1:0] rf_r_data2,
  input  logic            wb_en,
  input  logic [4:0]      wb_reg,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [IW-1:0]   out_inst
);
  logic            r_s1_valid, r_out_valid, r_fwd_hit1, r_fwd_hit2;
  logic [4:0]      r_s1_rs1, r_s1_rs2, r_out_rs1, r_out_rs2;
  logic [IW-1:0]   r_s1_inst, r_out_inst;
  logic [XLEN-1:0] r_fwd_data1, r_fwd_data2, r_out_d1, r_out_d2;
  logic            w_s1_adv, w_accept, w_hold, w_snoop1, w_snoop2;
  logic [XLEN-1:0] w_op1, w_op2;

  assign w_s1_adv     = r_s1_valid && (!r_out_valid || out_ready) && !flush;
  assign in_ready     = !flush && (!r_s1_valid || w_s1_adv);
  assign w_accept     = in_valid && in_ready;
  assign rf_r_reg1    = in_ready ? in_rs1 : r_s1_rs1;
  assign rf_r_reg2    = in_ready ? in_rs2 : r_s1_rs2;
  assign w_op1        = r_s1_rs1 == 5'd0 ? '0 : r_fwd_hit1 ? r_fwd_data1 : rf_r_data1;
  assign w_op2        = r_s1_rs2 == 5'd0 ? '0 : r_fwd_hit2 ? r_fwd_data2 : rf_r_data2;
  assign w_hold       = r_out_valid && !out_ready && !flush;
  assign w_snoop1     = w_hold && wb_en && wb_reg != 5'd0 && wb_reg == r_out_rs1;
  assign w_snoop2     = w_hold && wb_en && wb_reg != 5'd0 && wb_reg == r_out_rs2;
  assign out_valid    = r_out_valid;
  assign out_rs1_data = r_out_d1;
  assign out_rs2_data = r_out_d2;
  assign out_inst     = r_out_inst;

  // Capture writebacks aimed at the addresses read this cycle, since the register file returns pre-write data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fwd_hit1  <= 1'b0;
      r_fwd_hit2  <= 1'b0;
      r_fwd_data1 <= '0;
      r_fwd_data2 <= '0;
    end else begin
      r_fwd_hit1  <= wb_en && wb_reg != 5'd0 && wb_reg == rf_r_reg1;
      r_fwd_hit2  <= wb_en && wb_reg != 5'd0 && wb_reg == rf_r_reg2;
      r_fwd_data1 <= wb_data;
      r_fwd_data2 <= wb_data;
    end
  end

  // Read slot: take a new instruction on accept, empty on advance or flush
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
      r_s1_inst  <= '0;
    end else begin
      r_s1_valid <= w_accept || (r_s1_valid && !w_s1_adv && !flush);
      if (w_accept) begin
        r_s1_rs1  <= in_rs1;
        r_s1_rs2  <= in_rs2;
        r_s1_inst <= in_inst;
      end
    end
  end

  // Output slot: load resolved operands on advance, otherwise keep operands current while stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_rs1   <= '0;
      r_out_rs2   <= '0;
      r_out_d1    <= '0;
      r_out_d2    <= '0;
      r_out_inst  <= '0;
    end else begin
      r_out_valid <= !flush && (w_s1_adv || (r_out_valid && !out_ready));
      if (w_s1_adv) begin
        r_out_rs1  <= r_s1_rs1;
        r_out_rs2  <= r_s1_rs2;
        r_out_d1   <= w_op1;
        r_out_d2   <= w_op2;
        r_out_inst <= r_s1_inst;
      end else begin
        r_out_d1 <= w_snoop1 ? wb_data : r_out_d1;
        r_out_d2 <= w_snoop2 ? wb_data : r_out_d2;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed stimulus with a transaction-level model of the operand stage and a simple register file
module tb_operand_fetch;
  logic        clk, rstn, in_valid, in_ready, wb_en, flush, out_valid, out_ready;
  logic [4:0]  in_rs1, in_rs2, rf_r_reg1, rf_r_reg2, wb_reg;
  logic [31:0] in_inst, out_inst;
  logic [63:0] rf_r_data1, rf_r_data2, wb_data, out_rs1_data, out_rs2_data;
  logic [63:0] rf [32];
  int          n_checks = 0;
  int          n_err = 0;

  operand_fetch #(.XLEN(64), .IW(32)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_inst(in_inst),
    .rf_r_reg1(rf_r_reg1), .rf_r_reg2(rf_r_reg2),
    .rf_r_data1(rf_r_data1), .rf_r_data2(rf_r_data2),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_inst(out_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain register file: stores every write (x0 included), registered read returning pre-write data
  always @(posedge clk) begin
    if (wb_en) rf[wb_reg] <= wb_data;
    rf_r_data1 <= rf[rf_r_reg1];
    rf_r_data2 <= rf[rf_r_reg2];
  end

  // Model: an instruction takes the architectural register value in the cycle it leaves the read slot,
  // and while it waits in the output slot it follows later writebacks to its sources.
  logic        m_s1v, m_outv;
  logic [4:0]  m_s1r1, m_s1r2, m_or1, m_or2;
  logic [31:0] m_s1i, m_oi;
  logic [63:0] m_od1, m_od2;
  logic        m_adv, m_acc, m_in_ready;
  assign m_adv      = m_s1v && (!m_outv || out_ready) && !flush;
  assign m_in_ready = !flush && (!m_s1v || m_adv);
  assign m_acc      = in_valid && m_in_ready;

  function automatic logic [63:0] arch(input logic [4:0] r);
    return r == 5'd0 ? 64'd0 : rf[r];
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_s1v  <= 1'b0;
      m_outv <= 1'b0;
    end else begin
      if (flush) m_outv <= 1'b0;
      else if (m_adv) begin
        m_outv <= 1'b1;
        m_or1  <= m_s1r1;
        m_or2  <= m_s1r2;
        m_od1  <= arch(m_s1r1);
        m_od2  <= arch(m_s1r2);
        m_oi   <= m_s1i;
      end else if (out_ready) m_outv <= 1'b0;
      else if (m_outv && wb_en && wb_reg != 5'd0) begin
        if (wb_reg == m_or1) m_od1 <= wb_data;
        if (wb_reg == m_or2) m_od2 <= wb_data;
      end
      if (flush) m_s1v <= 1'b0;
      else if (m_acc) begin
        m_s1v  <= 1'b1;
        m_s1r1 <= in_rs1;
        m_s1r2 <= in_rs2;
        m_s1i  <= in_inst;
      end else if (m_adv) m_s1v <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rstn) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, m_in_ready});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_outv});
      chk("rf_r_reg1", {59'd0, rf_r_reg1}, {59'd0, m_in_ready ? in_rs1 : m_s1r1});
      chk("rf_r_reg2", {59'd0, rf_r_reg2}, {59'd0, m_in_ready ? in_rs2 : m_s1r2});
      if (m_outv) begin
        chk("out_rs1_data", out_rs1_data, m_od1);
        chk("out_rs2_data", out_rs2_data, m_od2);
        chk("out_inst", {32'd0, out_inst}, {32'd0, m_oi});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [63:0] d1, input logic [63:0] d2, input logic [31:0] ins);
    @(negedge clk);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_d1"}, out_rs1_data, d1);
    chk({tag, "_d2"}, out_rs2_data, d2);
    chk({tag, "_inst"}, {32'd0, out_inst}, {32'd0, ins});
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] ins);
    in_valid = 1'b1;
    in_rs1   = r1;
    in_rs2   = r2;
    in_inst  = ins;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [63:0] d);
    wb_en   = en;
    wb_reg  = r;
    wb_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_inst = '0;
    flush = 1'b0; out_ready = 1'b1; wb(1'b0, 5'd0, 64'd0);
    repeat (3) tick;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_d1", out_rs1_data, 64'd0);
    chk("rst_inst", {32'd0, out_inst}, 64'd0);
    tick;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    tick;
    wb(1'b1, 5'd5, 64'h11); tick;
    wb(1'b1, 5'd6, 64'h22); tick;
    wb(1'b1, 5'd7, 64'h70); tick;
    wb(1'b0, 5'd0, 64'd0); tick;
    issue(5'd5, 5'd6, 32'hA000_0001); tick;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", {63'd0, out_valid}, 64'd0);
    tick;
    expect_out("basic", 64'h11, 64'h22, 32'hA000_0001);
    tick;
    issue(5'd5, 5'd6, 32'd2); wb(1'b1, 5'd5, 64'hAA); tick;
    in_valid = 1'b0; wb(1'b0, 5'd0, 64'd0); tick;
    expect_out("bypass", 64'hAA, 64'h22, 32'd2);
    tick;
    issue(5'd0, 5'd0, 32'd3); wb(1'b1, 5'd0, 64'hFF); tick;
    in_valid = 1'b0; wb(1'b0, 5'd0, 64'd0); tick;
    expect_out("x0", 64'd0, 64'd0, 32'd3);
    tick;
    issue(5'd5, 5'd6, 32'd4); tick;
    issue(5'd6, 5'd5, 32'd5); tick;
    issue(5'd7, 5'd7, 32'd6); tick;
    in_valid = 1'b0;
    expect_out("stream", 64'h22, 64'hAA, 32'd5);
    repeat (3) tick;
    out_ready = 1'b0;
    issue(5'd7, 5'd7, 32'd7); tick;
    issue(5'd5, 5'd6, 32'd8); tick;
    issue(5'd6, 5'd6, 32'd9); tick;
    wb(1'b1, 5'd7, 64'h77); tick;
    wb(1'b0, 5'd0, 64'd0);
    expect_out("snoop", 64'h77, 64'h77, 32'd7);
    chk("snoop_in_ready", {63'd0, in_ready}, 64'd0);
    tick;
    tick;
    out_ready = 1'b1; tick;
    in_valid = 1'b0;
    expect_out("drain_b", 64'hAA, 64'h22, 32'd8);
    tick;
    expect_out("drain_c", 64'h22, 64'h22, 32'd9);
    tick;
    issue(5'd5, 5'd6, 32'd10); tick;
    issue(5'd6, 5'd7, 32'd11); tick;
    issue(5'd5, 5'd5, 32'd12); flush = 1'b1; tick;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    tick;
    @(negedge clk);
    chk("flush_no_accept", {63'd0, out_valid}, 64'd0);
    tick;
    out_ready = 1'b0;
    issue(5'd5, 5'd6, 32'd13); tick;
    in_valid = 1'b0; tick;
    #2;
    chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_d1", out_rs1_data, 64'd0);
    chk("async_rst_d2", out_rs2_data, 64'd0);
    chk("async_rst_inst", {32'd0, out_inst}, 64'd0);
    tick;
    rstn = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    tick;
    issue(5'd7, 5'd0, 32'd14); tick;
    in_valid = 1'b0; tick;
    expect_out("post_rst", 64'h77, 64'd0, 32'd14);
    repeat (3) tick;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width.
REQ-002 SHALL have parameter IW, default 32, width of the instruction word passed through.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_rs1 (input, 5), in_rs2 (input, 5), in_inst (input, IW): decoded-instruction handshake from decode.
REQ-006 SHALL have ports rf_r_reg1 and rf_r_reg2 (output, 5 each): read addresses to the register file, whose read data returns registered one cycle later.
REQ-007 SHALL have ports rf_r_data1 and rf_r_data2 (input, XLEN each): register-file read data.
REQ-008 SHALL have ports wb_en (input, 1), wb_reg (input, 5), wb_data (input, XLEN): the same writeback bus that drives the register-file write port.
REQ-009 SHALL have port flush, input, 1: kills all in-flight instructions.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_rs1_data and out_rs2_data (output, XLEN each), out_inst (output, IW): operand handshake to execute.

Function
REQ-011 SHALL be a two-slot pipeline: read slot S1 (s1_valid, s1_rs1, s1_rs2, s1_inst) and output slot OUT (out_valid, out_rs1, out_rs2, out data, out_inst).
REQ-012 SHALL define s1_adv = s1_valid && (!out_valid || out_ready) && !flush.
REQ-013 SHALL drive in_ready = !flush && (!s1_valid || s1_adv), combinationally; an accept occurs when in_valid && in_ready.
REQ-014 SHALL drive rf_r_reg1/2 = in_rs1/in_rs2 when in_ready, else s1_rs1/s1_rs2, so a held S1 entry re-reads every cycle.
REQ-015 SHALL register, each cycle, per read port: fwd_hit = wb_en && wb_reg == presented address && wb_reg != 0, and fwd_data = wb_data (covers the register-file write/read same-edge hazard).
REQ-016 SHALL resolve each S1 operand as 0 if its source is x0, else fwd_data if fwd_hit, else rf_r_data.
REQ-017 SHALL load OUT from S1 (resolved operands, sources, inst) and set out_valid=1 on s1_adv; clear out_valid when out_ready && !s1_adv.
REQ-018 SHALL, while OUT holds (out_valid && !out_ready), overwrite out_rs1_data (resp. rs2) with wb_data when wb_en && wb_reg == out_rs1 (resp. out_rs2) && wb_reg != 0; both update when rs1 == rs2.
REQ-019 SHALL give 2-cycle latency: accept at edge T -> out_valid high after edge T+1; sustained throughput 1 instruction/cycle with out_ready=1.
REQ-020 SHALL, on flush, clear s1_valid and out_valid at the next edge, accept nothing that cycle, and leave data registers unchanged.
REQ-021 SHALL never write to or hardwire the register file; x0 zeroing is performed solely here.
REQ-022 SHALL keep out_* data, out_inst stable while out_valid && !out_ready except per REQ-018.

Reset
REQ-023 SHALL, on rstn low, asynchronously clear s1_valid, out_valid, fwd_hit, and all data/address registers to 0; out_rs1_data = out_rs2_data = 0, out_inst = 0.
REQ-024 SHALL drive in_ready = 1 in the first cycle after rstn deasserts; reset mid-operation discards all in-flight entries.

Verification
REQ-025 Basic: x5=0x11, x6=0x22 preloaded; accept rs1=5, rs2=6, out_ready=1 -> out_valid two edges later with 0x11/0x22, inst unchanged.
REQ-026 Same-cycle bypass: wb_en=1, wb_reg=5, wb_data=0xAA in accept cycle of rs1=5 -> out_rs1_data=0xAA, not the old value.
REQ-027 x0: wb_en=1, wb_reg=0, wb_data=0xFF; accept rs1=0, rs2=0 -> both operands 0.
REQ-028 Backpressure snoop: out_ready=0 for 4 cycles with OUT holding rs1=rs2=7; write x7=0x77 in cycle 2 -> both operands become 0x77, S1 holds, in_ready=0, no loss or duplication when out_ready returns.
REQ-029 Flush: two entries in flight, flush=1 with in_valid=1 -> next cycle out_valid=0, s1 empty, flushed-cycle input not accepted.
REQ-030 Reset: rstn low while out_valid=1 -> out_valid=0 and data 0 immediately, in_ready=1 after release.
